// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle for one pipeline stage register
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // master: the surrounding pipeline (producer on the input side, consumer on the output side)
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // slave: the stage register itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and optional skid entry
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter bit SKID  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    pipe_stage_reg_if.slave        bus,
    output logic [1:0]             count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_ready_raw;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // In skid mode ready comes only from state flops, so out_ready never reaches in_ready;
    // without the skid entry a stalled main register can only be refilled if it drains this cycle.
    generate
        if (SKID) begin : g_skid_ready
            assign w_ready_raw = (r_state != FULL);
        end else begin : g_pass_ready
            assign w_ready_raw = (r_state == EMPTY) | bus.out_ready;
        end
    endgenerate

    // Outputs are forced idle while reset is held low, even before the first reset edge lands.
    assign w_in_ready    = reset & w_ready_raw;
    assign w_in_fire     = bus.in_valid & w_in_ready;
    assign w_out_fire    = (r_state != EMPTY) & bus.out_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = reset & (r_state != EMPTY);
    assign bus.out_data  = reset ? r_main : '0;

    // Entry count decoded from the state, zero while in reset.
    always_comb begin
        count = 2'd0;
        if (reset) begin
            unique case (r_state)
                BUSY:    count = 2'd1;
                FULL:    count = 2'd2;
                default: count = 2'd0;
            endcase
        end
    end

    // Next-state and storage update; flush overrides the handshake and discards any same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        unique case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = BUSY;
                    w_main_nxt  = bus.in_data;
                end
            end
            BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = bus.in_data;
                end else if (w_in_fire && SKID) begin
                    w_state_nxt = FULL;
                    w_skid_nxt  = bus.in_data;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = '0;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    w_state_nxt = BUSY;
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_main_nxt  = '0;
                w_skid_nxt  = '0;
            end
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in skid and single-entry modes
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush1;
    logic        flush0;
    logic [1:0]  count1;
    logic [1:0]  count0;
    int          total;
    int          bad;

    pipe_stage_reg_if #(.WIDTH(32)) if1 ();
    pipe_stage_reg_if #(.WIDTH(32)) if0 ();

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .bus(if1), .count(count1)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .bus(if0), .count(count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_full_ab();
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.in_data   = 32'hA;
        next_cycle();
        if1.in_data   = 32'hB;
        next_cycle();
        if1.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid1 got=%b want=0", if1.out_valid); end
        total++; if (if1.out_data !== 32'h0) begin bad++; $display("FAIL rst_data1 got=%h want=0", if1.out_data); end
        total++; if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b want=0", if1.in_ready); end
        total++; if (count1 !== 2'd0) begin bad++; $display("FAIL rst_count1 got=%0d want=0", count1); end
        total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b want=0", if0.in_ready); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL rel_ready1 got=%b want=1", if1.in_ready); end
        total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL rel_ready0 got=%b want=1", if0.in_ready); end
        next_cycle();
    endtask

    task automatic test_streaming();
        for (int i = 0; i <= 8; i++) begin
            if1.in_valid  = (i < 8);
            if1.in_data   = i + 1;
            if1.out_ready = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                total++; if (if1.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, if1.out_valid); end
                total++; if (if1.out_data !== 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, if1.out_data, i); end
                total++; if (count1 !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", i, count1); end
            end
            total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, if1.in_ready); end
            next_cycle();
        end
        @(negedge clk);
        total++; if (count1 !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0d want=0", count1); end
        next_cycle();
    endtask

    task automatic test_stall_skid();
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.in_data   = 32'hA;
        next_cycle();
        if1.in_data   = 32'hB;
        @(negedge clk);
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_busy got=%b want=1", if1.in_ready); end
        next_cycle();
        if1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (count1 !== 2'd2) begin bad++; $display("FAIL stall_count[%0d] got=%0d want=2", i, count1); end
            total++; if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, if1.in_ready); end
            total++; if (if1.out_data !== 32'hA) begin bad++; $display("FAIL stall_hold[%0d] got=%h want=a", i, if1.out_data); end
            next_cycle();
        end
        if1.out_ready = 1'b1;
        @(negedge clk);
        total++; if (if1.out_data !== 32'hA) begin bad++; $display("FAIL drain_first got=%h want=a", if1.out_data); end
        total++; if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL drain_ready0 got=%b want=0", if1.in_ready); end
        next_cycle();
        @(negedge clk);
        total++; if (if1.out_data !== 32'hB) begin bad++; $display("FAIL drain_second got=%h want=b", if1.out_data); end
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready1 got=%b want=1", if1.in_ready); end
        total++; if (count1 !== 2'd1) begin bad++; $display("FAIL drain_count got=%0d want=1", count1); end
        next_cycle();
        @(negedge clk);
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", if1.out_valid); end
        next_cycle();
    endtask

    task automatic test_flush();
        fill_full_ab();
        flush1       = 1'b1;
        if1.in_valid = 1'b1;
        if1.in_data  = 32'hC;
        next_cycle();
        flush1       = 1'b0;
        if1.in_valid = 1'b0;
        @(negedge clk);
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", if1.out_valid); end
        total++; if (if1.out_data !== 32'h0) begin bad++; $display("FAIL flush_data got=%h want=0", if1.out_data); end
        total++; if (count1 !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count1); end
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", if1.in_ready); end
        if1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost[%0d] got=%b want=0", i, if1.out_valid); end
        end
        next_cycle();
    endtask

    task automatic test_skid0();
        if0.in_valid  = 1'b1;
        if0.in_data   = 32'h11;
        if0.out_ready = 1'b0;
        next_cycle();
        if0.in_data   = 32'h22;
        @(negedge clk);
        total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL s0_stall_ready got=%b want=0", if0.in_ready); end
        total++; if (count0 !== 2'd1) begin bad++; $display("FAIL s0_count got=%0d want=1", count0); end
        total++; if (if0.out_data !== 32'h11) begin bad++; $display("FAIL s0_data1 got=%h want=11", if0.out_data); end
        if0.out_ready = 1'b1;
        #1;
        total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL s0_comb_ready got=%b want=1", if0.in_ready); end
        next_cycle();
        if0.in_valid = 1'b0;
        @(negedge clk);
        total++; if (if0.out_data !== 32'h22) begin bad++; $display("FAIL s0_data2 got=%h want=22", if0.out_data); end
        total++; if (count0 !== 2'd1) begin bad++; $display("FAIL s0_count2 got=%0d want=1", count0); end
        next_cycle();
        @(negedge clk);
        total++; if (count0 !== 2'd0) begin bad++; $display("FAIL s0_drain got=%0d want=0", count0); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        fill_full_ab();
        @(negedge clk);
        total++; if (count1 !== 2'd2) begin bad++; $display("FAIL rm_pre_count got=%0d want=2", count1); end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid[%0d] got=%b want=0", i, if1.out_valid); end
            total++; if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL rm_ready[%0d] got=%b want=0", i, if1.in_ready); end
            total++; if (count1 !== 2'd0) begin bad++; $display("FAIL rm_count[%0d] got=%0d want=0", i, count1); end
            next_cycle();
        end
        reset         = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 32'h5A;
        if1.out_ready = 1'b1;
        @(negedge clk);
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL rm_rel_ready got=%b want=1", if1.in_ready); end
        next_cycle();
        if1.in_valid = 1'b0;
        @(negedge clk);
        total++; if (if1.out_valid !== 1'b1) begin bad++; $display("FAIL rm_after_valid got=%b want=1", if1.out_valid); end
        total++; if (if1.out_data !== 32'h5A) begin bad++; $display("FAIL rm_after_data got=%h want=5a", if1.out_data); end
        total++; if (count1 !== 2'd1) begin bad++; $display("FAIL rm_after_count got=%0d want=1", count1); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] q1[$];
        logic [31:0] q0[$];
        logic        e_rdy1, e_rdy0, e_val1, e_val0;
        logic [31:0] e_dat1, e_dat0;
        logic        f1, f0, if_1, if_0, of_1, of_0;
        // Start both stages from a known-empty point.
        flush1 = 1'b1;
        flush0 = 1'b1;
        next_cycle();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if1.in_valid  = ($urandom_range(0, 3) != 0);
            if1.out_ready = ($urandom_range(0, 2) != 0);
            if1.in_data   = $urandom;
            flush1        = ($urandom_range(0, 9) == 0);
            if0.in_valid  = ($urandom_range(0, 3) != 0);
            if0.out_ready = ($urandom_range(0, 2) != 0);
            if0.in_data   = $urandom;
            flush0        = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            // Reference: a FIFO of capacity 2 (skid) or a pass-through slot of capacity 1.
            e_rdy1 = (q1.size() < 2);
            e_rdy0 = (q0.size() == 0) || if0.out_ready;
            e_val1 = (q1.size() != 0);
            e_val0 = (q0.size() != 0);
            e_dat1 = e_val1 ? q1[0] : 32'h0;
            e_dat0 = e_val0 ? q0[0] : 32'h0;
            total++; if (if1.in_ready !== e_rdy1) begin bad++; $display("FAIL rnd_ready1 c=%0d got=%b want=%b", cyc, if1.in_ready, e_rdy1); end
            total++; if (if1.out_valid !== e_val1) begin bad++; $display("FAIL rnd_valid1 c=%0d got=%b want=%b", cyc, if1.out_valid, e_val1); end
            total++; if (if1.out_data !== e_dat1) begin bad++; $display("FAIL rnd_data1 c=%0d got=%h want=%h", cyc, if1.out_data, e_dat1); end
            total++; if (count1 !== 2'(q1.size())) begin bad++; $display("FAIL rnd_count1 c=%0d got=%0d want=%0d", cyc, count1, q1.size()); end
            total++; if (if0.in_ready !== e_rdy0) begin bad++; $display("FAIL rnd_ready0 c=%0d got=%b want=%b", cyc, if0.in_ready, e_rdy0); end
            total++; if (if0.out_valid !== e_val0) begin bad++; $display("FAIL rnd_valid0 c=%0d got=%b want=%b", cyc, if0.out_valid, e_val0); end
            total++; if (if0.out_data !== e_dat0) begin bad++; $display("FAIL rnd_data0 c=%0d got=%h want=%h", cyc, if0.out_data, e_dat0); end
            total++; if (count0 !== 2'(q0.size())) begin bad++; $display("FAIL rnd_count0 c=%0d got=%0d want=%0d", cyc, count0, q0.size()); end
            f1   = flush1;
            f0   = flush0;
            if_1 = if1.in_valid && e_rdy1;
            if_0 = if0.in_valid && e_rdy0;
            of_1 = e_val1 && if1.out_ready;
            of_0 = e_val0 && if0.out_ready;
            @(posedge clk);
            if (f1) q1.delete();
            else begin
                if (of_1) void'(q1.pop_front());
                if (if_1) q1.push_back(if1.in_data);
            end
            if (f0) q0.delete();
            else begin
                if (of_0) void'(q0.pop_front());
                if (if_0) q0.push_back(if0.in_data);
            end
            #1;
        end
        flush1       = 1'b0;
        flush0       = 1'b0;
        if1.in_valid = 1'b0;
        if0.in_valid = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        flush1        = 1'b0;
        flush0        = 1'b0;
        if1.in_valid  = 1'b0;
        if1.in_data   = 32'h0;
        if1.out_ready = 1'b0;
        if0.in_valid  = 1'b0;
        if0.in_data   = 32'h0;
        if0.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_skid0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
